// File: rtl/regfile_param.sv
// Two-write, two-read register file with pending bits and a sequential clear.
// Optional macro REGFILE_BYPASS_EN forwards same-cycle write data to the read ports.
module regfile_param #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1
) (
    input  logic              i_clk,
    input  logic              i_arst,
    input  logic              i_we0,
    input  logic [ADDR_W-1:0] i_waddr0,
    input  logic [DATA_W-1:0] i_wdata0,
    input  logic              i_we1,
    input  logic [ADDR_W-1:0] i_waddr1,
    input  logic [DATA_W-1:0] i_wdata1,
    input  logic [ADDR_W-1:0] i_raddr_a,
    input  logic [ADDR_W-1:0] i_raddr_b,
    output logic [DATA_W-1:0] o_rdata_a,
    output logic [DATA_W-1:0] o_rdata_b,
    input  logic              i_rsv,
    input  logic [ADDR_W-1:0] i_rsv_addr,
    output logic              o_pend_a,
    output logic              o_pend_b,
    input  logic              i_clr,
    output logic              o_busy
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  pend;
    logic              busy, zr, acc0, acc1, rsv_ok;

    assign busy   = (state_q == CLEAR);
    assign o_busy = busy;
    assign zr     = (ZERO_REG != 0);
    assign acc0   = i_we0 && !busy && !(zr && i_waddr0 == '0);
    assign acc1   = i_we1 && !busy && !(zr && i_waddr1 == '0);
    assign rsv_ok = i_rsv && !busy;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (i_clr) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                end
            end
            CLEAR: begin
                if (cnt_q == '1) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Later assignments take priority: port 1 over port 0, reserve over write-clear.
    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            pend <= '0;
        end else if (busy) begin
            mem[cnt_q]  <= '0;
            pend[cnt_q] <= 1'b0;
        end else begin
            if (acc0) begin
                mem[i_waddr0]  <= i_wdata0;
                pend[i_waddr0] <= 1'b0;
            end
            if (acc1) begin
                mem[i_waddr1]  <= i_wdata1;
                pend[i_waddr1] <= 1'b0;
            end
            if (rsv_ok) pend[i_rsv_addr] <= 1'b1;
        end
    end

    always_comb begin
        o_rdata_a = mem[i_raddr_a];
        o_rdata_b = mem[i_raddr_b];
        o_pend_a  = pend[i_raddr_a];
        o_pend_b  = pend[i_raddr_b];
`ifdef REGFILE_BYPASS_EN
        if (acc0 && i_waddr0 == i_raddr_a) begin
            o_rdata_a = i_wdata0;
            o_pend_a  = 1'b0;
        end
        if (acc1 && i_waddr1 == i_raddr_a) begin
            o_rdata_a = i_wdata1;
            o_pend_a  = 1'b0;
        end
        if (rsv_ok && i_rsv_addr == i_raddr_a) o_pend_a = 1'b1;
        if (acc0 && i_waddr0 == i_raddr_b) begin
            o_rdata_b = i_wdata0;
            o_pend_b  = 1'b0;
        end
        if (acc1 && i_waddr1 == i_raddr_b) begin
            o_rdata_b = i_wdata1;
            o_pend_b  = 1'b0;
        end
        if (rsv_ok && i_rsv_addr == i_raddr_b) o_pend_b = 1'b1;
`endif
        if (zr && i_raddr_a == '0) begin
            o_rdata_a = '0;
            o_pend_a  = 1'b0;
        end
        if (zr && i_raddr_b == '0) begin
            o_rdata_b = '0;
            o_pend_b  = 1'b0;
        end
    end

endmodule

// File: tb/tb_regfile_param.sv
// Scoreboard bench for regfile_param: expected values queued at stimulus,
// popped and compared when the DUT outputs are sampled.
module tb_regfile_param;

    logic        i_clk = 1'b0;
    logic        i_arst;
    logic        i_we0, i_we1, i_rsv, i_clr;
    logic [4:0]  i_waddr0, i_waddr1, i_raddr_a, i_raddr_b, i_rsv_addr;
    logic [31:0] i_wdata0, i_wdata1;
    logic [31:0] o_rdata_a, o_rdata_b;
    logic        o_pend_a, o_pend_b, o_busy;

    int total = 0;
    int bad   = 0;

    logic [31:0] exp_q [$];
    logic [31:0] mdl [32];
    logic        mpend [32];

    regfile_param dut (
        .i_clk(i_clk), .i_arst(i_arst),
        .i_we0(i_we0), .i_waddr0(i_waddr0), .i_wdata0(i_wdata0),
        .i_we1(i_we1), .i_waddr1(i_waddr1), .i_wdata1(i_wdata1),
        .i_raddr_a(i_raddr_a), .i_raddr_b(i_raddr_b),
        .o_rdata_a(o_rdata_a), .o_rdata_b(o_rdata_b),
        .i_rsv(i_rsv), .i_rsv_addr(i_rsv_addr),
        .o_pend_a(o_pend_a), .o_pend_b(o_pend_b),
        .i_clr(i_clr), .o_busy(o_busy)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic idle_in();
        i_we0 = 0; i_we1 = 0; i_rsv = 0; i_clr = 0;
    endtask

    task automatic mdl_reset();
        for (int i = 0; i < 32; i++) begin
            mdl[i]   = '0;
            mpend[i] = 1'b0;
        end
    endtask

    // Queue the expectation for register a, then compare data and pend on both ports.
    task automatic rd(input string tag, input logic [4:0] a);
        i_raddr_a = a;
        i_raddr_b = a;
        exp_q.push_back(a == 0 ? 32'h0 : mdl[a]);
        exp_q.push_back({31'b0, a == 0 ? 1'b0 : mpend[a]});
        #1;
        begin
            logic [31:0] ed, ep;
            ed = exp_q.pop_front();
            ep = exp_q.pop_front();
            chk({tag, "_a"}, o_rdata_a, ed);
            chk({tag, "_b"}, o_rdata_b, ed);
            chk({tag, "_pa"}, {31'b0, o_pend_a}, ep);
            chk({tag, "_pb"}, {31'b0, o_pend_b}, ep);
        end
    endtask

    task automatic wr(input bit port, input logic [4:0] a, input logic [31:0] d);
        if (port == 0) begin
            i_we0 = 1; i_waddr0 = a; i_wdata0 = d;
        end else begin
            i_we1 = 1; i_waddr1 = a; i_wdata1 = d;
        end
        step();
        idle_in();
        if (a != 0) begin
            mdl[a]   = d;
            mpend[a] = 1'b0;
        end
    endtask

    initial begin
        int n;
        idle_in();
        i_waddr0 = 0; i_waddr1 = 0; i_wdata0 = 0; i_wdata1 = 0;
        i_raddr_a = 0; i_raddr_b = 0; i_rsv_addr = 0;
        i_arst = 1;
        mdl_reset();
        repeat (3) step();
        i_arst = 0;
        step();

        exp_q.push_back(32'h0);
        chk("rst_busy", {31'b0, o_busy}, exp_q.pop_front());
        rd("rst_r0", 0);
        rd("rst_r5", 5);
        rd("rst_r31", 31);

        wr(0, 5, 32'hDEADBEEF);
        rd("w5", 5);

        i_we0 = 1; i_waddr0 = 7; i_wdata0 = 32'h1111;
        i_we1 = 1; i_waddr1 = 7; i_wdata1 = 32'h2222;
        step();
        idle_in();
        mdl[7] = 32'h2222;
        rd("prio7", 7);

        wr(1, 0, 32'hFFFFFFFF);
        rd("zero", 0);
        i_rsv = 1; i_rsv_addr = 0;
        step();
        idle_in();
        rd("zero_pend", 0);

        i_rsv = 1; i_rsv_addr = 3;
        step();
        idle_in();
        mpend[3] = 1;
        rd("rsv3", 3);
        wr(0, 3, 32'h55);
        rd("wclr3", 3);
        i_rsv = 1; i_rsv_addr = 3;
        i_we1 = 1; i_waddr1 = 3; i_wdata1 = 32'h66;
        step();
        idle_in();
        mdl[3] = 32'h66;
        mpend[3] = 1;
        rd("rsvwr3", 3);

        wr(0, 9, 32'h1234);
        i_raddr_a = 9; i_raddr_b = 3;
        i_we0 = 1; i_waddr0 = 9; i_wdata0 = 32'hABCD;
        i_we1 = 1; i_waddr1 = 3; i_wdata1 = 32'h77;
`ifdef REGFILE_BYPASS_EN
        exp_q.push_back(32'hABCD);
        exp_q.push_back(32'h0);
`else
        exp_q.push_back(32'h1234);
        exp_q.push_back(32'h1);
`endif
        #1;
        chk("byp_data", o_rdata_a, exp_q.pop_front());
        chk("byp_pend", {31'b0, o_pend_b}, exp_q.pop_front());
        step();
        idle_in();
        mdl[9] = 32'hABCD;
        mdl[3] = 32'h77;
        mpend[3] = 0;
        rd("byp_next", 9);
        rd("byp_r3", 3);

        for (int i = 1; i < 32; i++) wr(i[0], 5'(i), 32'h0101_0101 * i);
        i_rsv = 1; i_rsv_addr = 12;
        step();
        idle_in();
        mpend[12] = 1;
        rd("fill17", 17);
        rd("fill12", 12);

        i_clr = 1;
        step();
        i_we0 = 1; i_waddr0 = 30; i_wdata0 = 32'hBAD;
        i_rsv = 1; i_rsv_addr = 29;
        n = 0;
        while (o_busy && n < 100) begin
            n++;
            step();
        end
        idle_in();
        mdl_reset();
        exp_q.push_back(32'd32);
        chk("busy_len", n, exp_q.pop_front());
        for (int i = 0; i < 32; i++) rd("clr", 5'(i));
        step();
        exp_q.push_back(32'h0);
        chk("clr_norestart", {31'b0, o_busy}, exp_q.pop_front());

        for (int i = 1; i < 32; i++) wr(0, 5'(i), 32'hC000_0000 + i);
        i_rsv = 1; i_rsv_addr = 8;
        step();
        idle_in();
        mpend[8] = 1;
        rd("refill8", 8);
        i_clr = 1;
        step();
        idle_in();
        repeat (9) step();
        i_arst = 1;
        #1;
        mdl_reset();
        exp_q.push_back(32'h0);
        chk("abort_busy", {31'b0, o_busy}, exp_q.pop_front());
        rd("abort_r8", 8);
        rd("abort_r31", 31);
        step();
        i_arst = 0;
        step();
        exp_q.push_back(32'h0);
        chk("post_busy", {31'b0, o_busy}, exp_q.pop_front());
        for (int i = 0; i < 32; i++) rd("post", 5'(i));
        wr(1, 20, 32'h2020);
        rd("post_w20", 20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
